// File: rtl/gauss_3x3_pkg.sv
// ---------------------------------------------------------------------------
// gauss_3x3_pkg
//   Shared definitions for the 3x3 Gaussian smoothing stage.
//   - Kernel taps: the 3x3 kernel [1 2 1; 2 4 2; 1 2 1] is separable, so it is
//     stored as one 1-D tap vector applied first along rows, then across rows.
//   - KERNEL_SHIFT: normalisation shift (the kernel weights sum to 16).
//   - SUM_WIDTH of the full accumulation is DATA_WIDTH + KERNEL_SHIFT; the
//     per-row partial sum needs DATA_WIDTH + ROW_GROWTH bits.
//   - Window FSM encoding (WAIT_SOP = 0, FRAME = 1).
//   Optional feature macro used by the importing modules: GAUSS_3X3_BYPASS_EN.
// ---------------------------------------------------------------------------
package gauss_3x3_pkg;

  // Window sequencing state
  typedef enum logic {
    WAIT_SOP = 1'b0,
    FRAME    = 1'b1
  } win_state_e;

  // 1-D taps; index 0 is the leftmost column / top row.
  localparam logic [2:0][2:0] KERNEL_TAP = {3'd1, 3'd2, 3'd1};

  // Weights sum to 16 -> divide by 16 with round-half-up.
  localparam int unsigned KERNEL_SHIFT = 4;

  // Taps of one row sum to 4 -> two extra bits per row partial sum.
  localparam int unsigned ROW_GROWTH = 2;

  // Added before the shift so the division rounds half up.
  localparam int unsigned ROUND_BIAS = 1 << (KERNEL_SHIFT - 1);

  // Framing that travels alongside every window / pipeline stage.
  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } frame_flags_t;

endpackage

// File: rtl/gauss_3x3_window.sv
// ---------------------------------------------------------------------------
// window_3x3
//   Builds a 3x3 pixel window from a column-aligned triple of pixels
//   (current row, one row above, two rows above) and tracks the frame
//   position of every accepted pixel.
//
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     in_valid        : pixel qualifier (no backpressure)
//     in_sop          : first pixel of a frame (with in_valid)
//     data_in         : pixel at (x, y)
//     row1_in         : pixel at (x, y-1)
//     row2_in         : pixel at (x, y-2)
//     bypass          : (GAUSS_3X3_BYPASS_EN only) sampled with each column
//     win_bypass      : (GAUSS_3X3_BYPASS_EN only) bypass of the last column
//     win             : window registers, win[col][row]; col 0 is oldest
//                       (x-2), row 0 is the top (y-2), row 2 is y
//     win_flags       : valid/sop/eop of the window just completed; valid is a
//                       one-cycle pulse per accepted pixel with x>=2, y>=2
//     state_dbg       : FSM state, for observation
//
//   Optional feature macro: GAUSS_3X3_BYPASS_EN.
//
//   Handshake: a pixel is accepted on a clock edge where in_valid=1 and either
//   in_sop=1 or the FSM is in FRAME. There is no ready; every accepted pixel
//   shifts the window and advances the (x, y) position exactly once.
// ---------------------------------------------------------------------------
module window_3x3
  import gauss_3x3_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_sop,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [DATA_WIDTH-1:0]          row1_in,
  input  logic [DATA_WIDTH-1:0]          row2_in,
`ifdef GAUSS_3X3_BYPASS_EN
  input  logic                           bypass,
  output logic                           win_bypass,
`endif
  output logic [2:0][2:0][DATA_WIDTH-1:0] win,
  output frame_flags_t                   win_flags,
  output win_state_e                     state_dbg
);

  localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
  // First position at which the window holds three full columns and rows.
  localparam logic [XW-1:0] X_FULL  = XW'(2);
  localparam logic [YW-1:0] Y_FULL  = YW'(2);

  win_state_e state_q, state_d;
  // Position of the next pixel expected within the frame.
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;
  frame_flags_t flags_q, flags_d;

  // Position of the pixel presented this cycle (in_sop forces (0,0)).
  logic          accept;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    flags_d = '0;

    accept = in_valid && (in_sop || (state_q == FRAME));
    cur_x  = in_sop ? '0 : x_q;
    cur_y  = in_sop ? '0 : y_q;

    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = {data_in, row1_in, row2_in};

      flags_d.valid = (cur_x >= X_FULL) && (cur_y >= Y_FULL);
      flags_d.sop   = flags_d.valid && (cur_x == X_FULL) && (cur_y == Y_FULL);
      flags_d.eop   = flags_d.valid && (cur_x == X_LAST) && (cur_y == Y_LAST);

      state_d = FRAME;
      if (cur_x == X_LAST) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          y_d     = '0;
          state_d = WAIT_SOP;
        end else begin
          y_d = cur_y + YW'(1);
        end
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOP;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      flags_q <= flags_d;
    end
  end

`ifdef GAUSS_3X3_BYPASS_EN
  logic bypass_q, bypass_d;

  // Bypass belongs to the column it arrived with, so it only moves on accept.
  always_comb begin
    bypass_d = bypass_q;
    if (accept) begin
      bypass_d = bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else begin
      bypass_q <= bypass_d;
    end
  end

  assign win_bypass = bypass_q;
`endif

  assign win       = win_q;
  assign win_flags = flags_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/gauss_3x3.sv
// ---------------------------------------------------------------------------
// gauss_3x3
//   3x3 Gaussian smoothing of one pixel channel. Takes the current pixel and
//   the column-aligned pixels one and two lines above, forms a 3x3 window
//   (window_3x3) and emits the filtered centre pixel of every interior
//   position, with frame framing. Border centres are dropped.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     in_valid   : input pixel qualifier (no backpressure)
//     in_sop     : first pixel of a frame
//     data_in    : pixel at row y
//     row1_in    : pixel at row y-1, same column
//     row2_in    : pixel at row y-2, same column
//     bypass     : (GAUSS_3X3_BYPASS_EN only) emit unfiltered centre pixel
//     out_valid  : filtered pixel qualifier
//     out_sop    : first output pixel of a frame (centre (1,1))
//     out_eop    : last output pixel of a frame
//     data_out   : filtered pixel; holds its value while out_valid=0
//
//   Optional feature macro: GAUSS_3X3_BYPASS_EN (adds the bypass port).
//
//   Handshake: out_valid is a pure qualifier; there is no ready. The output
//   of a window completed at edge N appears after edge N+2.
//
//   Pipeline:
//     stage 1 : weighted row sums (1 2 1 across each window row)
//     stage 2 : weighted column sum (1 2 1 down the rows), rounding, output
// ---------------------------------------------------------------------------
module gauss_3x3
  import gauss_3x3_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] row1_in,
  input  logic [DATA_WIDTH-1:0] row2_in,
`ifdef GAUSS_3X3_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int ROW_WIDTH = DATA_WIDTH + ROW_GROWTH;
  localparam int SUM_WIDTH = DATA_WIDTH + KERNEL_SHIFT;

  // -------------------------------------------------------------------------
  // Window formation
  // -------------------------------------------------------------------------
  logic [2:0][2:0][DATA_WIDTH-1:0] win;
  frame_flags_t                    win_flags;
  // FSM state observation point for bound checkers; not used by the datapath.
  win_state_e                      window_state_unused;
`ifdef GAUSS_3X3_BYPASS_EN
  logic                            win_bypass;
`endif

  window_3x3 #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LINE_WIDTH  (LINE_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .data_in   (data_in),
    .row1_in   (row1_in),
    .row2_in   (row2_in),
`ifdef GAUSS_3X3_BYPASS_EN
    .bypass    (bypass),
    .win_bypass(win_bypass),
`endif
    .win       (win),
    .win_flags (win_flags),
    .state_dbg (window_state_unused)
  );

  // -------------------------------------------------------------------------
  // Arithmetic helpers: the separable kernel applied along one dimension.
  // -------------------------------------------------------------------------
  function automatic logic [ROW_WIDTH-1:0] weigh_row(
    input logic [DATA_WIDTH-1:0] left,
    input logic [DATA_WIDTH-1:0] mid,
    input logic [DATA_WIDTH-1:0] right
  );
    return ROW_WIDTH'(KERNEL_TAP[0]) * ROW_WIDTH'(left)
         + ROW_WIDTH'(KERNEL_TAP[1]) * ROW_WIDTH'(mid)
         + ROW_WIDTH'(KERNEL_TAP[2]) * ROW_WIDTH'(right);
  endfunction

  function automatic logic [SUM_WIDTH-1:0] weigh_col(
    input logic [ROW_WIDTH-1:0] top,
    input logic [ROW_WIDTH-1:0] mid,
    input logic [ROW_WIDTH-1:0] bot
  );
    return SUM_WIDTH'(KERNEL_TAP[0]) * SUM_WIDTH'(top)
         + SUM_WIDTH'(KERNEL_TAP[1]) * SUM_WIDTH'(mid)
         + SUM_WIDTH'(KERNEL_TAP[2]) * SUM_WIDTH'(bot);
  endfunction

  // -------------------------------------------------------------------------
  // Stage 1: row partial sums. Advances every clock.
  // -------------------------------------------------------------------------
  logic [2:0][ROW_WIDTH-1:0] row_sum_q, row_sum_d;
  logic [DATA_WIDTH-1:0]     s1_centre_q, s1_centre_d;
  frame_flags_t              s1_flags_q, s1_flags_d;

  always_comb begin
    row_sum_d[0] = weigh_row(win[0][0], win[1][0], win[2][0]);
    row_sum_d[1] = weigh_row(win[0][1], win[1][1], win[2][1]);
    row_sum_d[2] = weigh_row(win[0][2], win[1][2], win[2][2]);
    s1_centre_d  = win[1][1];
    s1_flags_d   = win_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sum_q   <= '0;
      s1_centre_q <= '0;
      s1_flags_q  <= '0;
    end else begin
      row_sum_q   <= row_sum_d;
      s1_centre_q <= s1_centre_d;
      s1_flags_q  <= s1_flags_d;
    end
  end

`ifdef GAUSS_3X3_BYPASS_EN
  logic s1_bypass_q, s1_bypass_d;

  always_comb begin
    s1_bypass_d = win_bypass;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_bypass_q <= 1'b0;
    end else begin
      s1_bypass_q <= s1_bypass_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Stage 2: full sum, round-half-up, output register.
  // The maximum sum (16 * max pixel) plus the bias still fits SUM_WIDTH, and
  // the quotient never exceeds the largest input, so no saturation.
  // -------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0]  sum;
  logic [SUM_WIDTH-1:0]  sum_rounded;
  logic [DATA_WIDTH-1:0] filtered;
  logic [DATA_WIDTH-1:0] result;

  frame_flags_t          out_flags_q, out_flags_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    sum         = weigh_col(row_sum_q[0], row_sum_q[1], row_sum_q[2]);
    sum_rounded = sum + SUM_WIDTH'(ROUND_BIAS);
    filtered    = sum_rounded[SUM_WIDTH-1:KERNEL_SHIFT];
`ifdef GAUSS_3X3_BYPASS_EN
    result      = s1_bypass_q ? s1_centre_q : filtered;
`else
    result      = filtered;
`endif

    out_flags_d = s1_flags_q;
    // Output data only changes with a qualified pixel; otherwise it holds.
    data_out_d  = data_out_q;
    if (s1_flags_q.valid) begin
      data_out_d = result;
    end
  end

`ifndef GAUSS_3X3_BYPASS_EN
  // The centre pixel is only needed when bypass exists.
  logic [DATA_WIDTH-1:0] s1_centre_unused;
  assign s1_centre_unused = s1_centre_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags_q <= '0;
      data_out_q  <= '0;
    end else begin
      out_flags_q <= out_flags_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid = out_flags_q.valid;
  assign out_sop   = out_flags_q.sop;
  assign out_eop   = out_flags_q.eop;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_gauss_3x3.sv
// ---------------------------------------------------------------------------
// tb_gauss_3x3
//   Self-checking bench for gauss_3x3 with an 8x6 frame. The reference model
//   holds the frame as a 2-D image and computes every interior output
//   directly from the kernel definition, timestamped two clocks after the
//   completing pixel. Row buffers are modelled by reading the image one and
//   two lines up. Build with GAUSS_3X3_BYPASS_EN to exercise bypass too.
// ---------------------------------------------------------------------------
module tb_gauss_3x3;

  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int FH    = 6;
  localparam int N_OUT = (LW - 2) * (FH - 2);

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic          in_valid;
  logic          in_sop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] row1_in;
  logic [DW-1:0] row2_in;
`ifdef GAUSS_3X3_BYPASS_EN
  logic          bypass;
`endif
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [DW-1:0] data_out;

  gauss_3x3 #(
    .DATA_WIDTH  (DW),
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .data_in  (data_in),
    .row1_in  (row1_in),
    .row2_in  (row2_in),
`ifdef GAUSS_3X3_BYPASS_EN
    .bypass   (bypass),
`endif
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .data_out (data_out)
  );

  // Scoreboard
  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] cap_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            frame_cnt = 0;
  logic [DW-1:0] last_data = '0;
  bit            mon_en = 1'b0;

  // Reference model state
  logic [DW-1:0] img [FH][LW];
  int            m_x = 0;
  int            m_y = 0;
  bit            m_in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Gaussian of the centre (cx, cy) straight from the kernel definition.
  function automatic logic [DW-1:0] model_pixel(input int cx, input int cy, input bit byp);
    int sum;
    int w;
    if (byp) return img[cy][cx];
    sum = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        w = ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
        sum += w * int'(img[cy + dy][cx + dx]);
      end
    end
    return DW'((sum + 8) / 16);
  endfunction

  // Output monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        exp_t e;
        frame_cnt = out_sop ? 1 : frame_cnt + 1;
        cap_q.push_back(data_out);
        last_data = data_out;
        check("exp_available", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(data_out), 32'(e.data));
          check("out_sop", 32'(out_sop), 32'(e.sop));
          check("out_eop", 32'(out_eop), 32'(e.eop));
          check("out_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("idle_sop", 32'(out_sop), 32'd0);
        check("idle_eop", 32'(out_eop), 32'd0);
        check("idle_hold", 32'(data_out), 32'(last_data));
      end
    end
  end

  // Driver: one pixel, then `gap` idle cycles.
  task automatic send_pixel(input logic [DW-1:0] v, input bit sop, input int gap, input bit byp);
    bit acc;
    int x;
    int y;
    if (sop) begin
      m_x = 0;
      m_y = 0;
      m_in_frame = 1'b1;
    end
    acc = m_in_frame;
    x = m_x;
    y = m_y;
    in_valid = 1'b1;
    in_sop   = sop;
    data_in  = v;
    if (acc) begin
      row1_in = img[(y + FH - 1) % FH][x];
      row2_in = img[(y + FH - 2) % FH][x];
    end else begin
      row1_in = DW'($urandom_range(0, 255));
      row2_in = DW'($urandom_range(0, 255));
    end
`ifdef GAUSS_3X3_BYPASS_EN
    bypass = byp;
`endif
    @(posedge clk);
    #1;
    if (acc) begin
      img[y][x] = v;
      if (x >= 2 && y >= 2) begin
        exp_q.push_back('{model_pixel(x - 1, y - 1, byp),
                          (x == 2 && y == 2), (x == LW - 1 && y == FH - 1), cyc + 2});
      end
      if (x == LW - 1) begin
        m_x = 0;
        if (y == FH - 1) begin
          m_y = 0;
          m_in_frame = 1'b0;
        end else begin
          m_y = y + 1;
        end
      end else begin
        m_x = x + 1;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind: 0 constant, 1 impulse at (3,2), 2 ramp x+8y, 3 random
  // gap_mode: 0 none, 1 one idle per pixel, 2 random 0..2
  // byp_mode: 0 off, 1 on, 2 random per pixel
  task automatic send_frame(input int kind, input logic [DW-1:0] val, input int gap_mode,
                            input int byp_mode, input int npix);
    logic [DW-1:0] v;
    int gap;
    bit byp;
    for (int i = 0; i < npix; i++) begin
      case (kind)
        0:       v = val;
        1:       v = (i == 2 * LW + 3) ? val : '0;
        2:       v = DW'((i % LW) + 8 * (i / LW));
        default: v = DW'($urandom_range(0, 255));
      endcase
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      byp = (byp_mode == 2) ? bit'($urandom_range(0, 1)) : (byp_mode == 1);
      send_pixel(v, (i == 0), gap, byp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_data  = '0;
    m_in_frame = 1'b0;
    m_x = 0;
    m_y = 0;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sop", 32'(out_sop), 32'd0);
    check("rst_out_eop", 32'(out_eop), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
  endtask

  // Stimulus tables
  typedef struct {
    logic [DW-1:0] pix;
    logic [DW-1:0] exp;
  } const_vec_t;

  typedef struct {
    int            cx;
    int            cy;
    logic [DW-1:0] exp;
  } imp_vec_t;

  const_vec_t    const_tab [3];
  imp_vec_t      imp_tab [9];
  logic [DW-1:0] imp_exp [N_OUT];
  logic [DW-1:0] ramp_ref[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    const_tab[0] = '{8'd100, 8'd100};
    const_tab[1] = '{8'd255, 8'd255};
    const_tab[2] = '{8'd0,   8'd0};

    imp_tab[0] = '{3, 2, 8'd40};
    imp_tab[1] = '{2, 2, 8'd20};
    imp_tab[2] = '{4, 2, 8'd20};
    imp_tab[3] = '{3, 1, 8'd20};
    imp_tab[4] = '{3, 3, 8'd20};
    imp_tab[5] = '{2, 1, 8'd10};
    imp_tab[6] = '{4, 1, 8'd10};
    imp_tab[7] = '{2, 3, 8'd10};
    imp_tab[8] = '{4, 3, 8'd10};

    for (int y = 0; y < FH; y++)
      for (int x = 0; x < LW; x++)
        img[y][x] = '0;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    data_in  = '0;
    row1_in  = '0;
    row2_in  = '0;
`ifdef GAUSS_3X3_BYPASS_EN
    bypass   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sop", 32'(out_sop), 32'd0);
    check("reset_out_eop", 32'(out_eop), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Constant frames, gap-free.
    for (int t = 0; t < 3; t++) begin
      cap_q.delete();
      frame_cnt = 0;
      send_frame(0, const_tab[t].pix, 0, 0, LW * FH);
      drain();
      check("const_count", 32'(cap_q.size()), 32'(N_OUT));
      check("const_frame_cnt", 32'(frame_cnt), 32'(N_OUT));
      foreach (cap_q[i]) check("const_value", 32'(cap_q[i]), 32'(const_tab[t].exp));
    end

    // Impulse frame.
    for (int i = 0; i < N_OUT; i++) imp_exp[i] = '0;
    foreach (imp_tab[i]) imp_exp[(imp_tab[i].cy - 1) * (LW - 2) + (imp_tab[i].cx - 1)] = imp_tab[i].exp;
    cap_q.delete();
    send_frame(1, 8'd160, 0, 0, LW * FH);
    drain();
    check("impulse_count", 32'(cap_q.size()), 32'(N_OUT));
    if (cap_q.size() == N_OUT)
      for (int i = 0; i < N_OUT; i++) check("impulse_value", 32'(cap_q[i]), 32'(imp_exp[i]));

    // Ramp, gap-free, then with in_valid toggling.
    cap_q.delete();
    send_frame(2, '0, 0, 0, LW * FH);
    drain();
    ramp_ref = cap_q;
    cap_q.delete();
    frame_cnt = 0;
    send_frame(2, '0, 1, 0, LW * FH);
    drain();
    check("ramp_gap_count", 32'(cap_q.size()), 32'(ramp_ref.size()));
    check("ramp_gap_frame_cnt", 32'(frame_cnt), 32'(N_OUT));
    if (cap_q.size() == ramp_ref.size())
      foreach (cap_q[i]) check("ramp_gap_vs_nogap", 32'(cap_q[i]), 32'(ramp_ref[i]));

    // in_sop at what would be pixel (5,3): 9 old outputs finish, new frame 24.
    cap_q.delete();
    send_frame(3, '0, 0, 0, 3 * LW + 5);
    frame_cnt = 0;
    send_frame(3, '0, 0, 0, LW * FH);
    drain();
    check("restart_total_outputs", 32'(cap_q.size()), 32'(9 + N_OUT));
    check("restart_frame_cnt", 32'(frame_cnt), 32'(N_OUT));

    // Reset pulse mid-frame, then pixels without in_sop are ignored.
    send_frame(3, '0, 0, 0, 3 * LW + 4);
    pulse_reset();
    cap_q.delete();
    for (int i = 0; i < 10; i++) send_pixel(DW'($urandom_range(0, 255)), 1'b0, 0, 1'b0);
    drain();
    check("post_reset_no_output", 32'(cap_q.size()), 32'd0);
    frame_cnt = 0;
    send_frame(3, '0, 2, 0, LW * FH);
    drain();
    check("post_reset_frame_cnt", 32'(frame_cnt), 32'(N_OUT));

    // Random frames with random gaps.
    for (int f = 0; f < 2; f++) begin
      frame_cnt = 0;
      send_frame(3, '0, 2, 0, LW * FH);
      drain();
      check("random_frame_cnt", 32'(frame_cnt), 32'(N_OUT));
    end

`ifdef GAUSS_3X3_BYPASS_EN
    // Bypass on the impulse frame: only centre (3,2) carries 160.
    cap_q.delete();
    send_frame(1, 8'd160, 0, 1, LW * FH);
    drain();
    check("bypass_count", 32'(cap_q.size()), 32'(N_OUT));
    if (cap_q.size() == N_OUT)
      for (int i = 0; i < N_OUT; i++)
        check("bypass_value", 32'(cap_q[i]), (i == (2 - 1) * (LW - 2) + (3 - 1)) ? 32'd160 : 32'd0);
    frame_cnt = 0;
    send_frame(3, '0, 2, 2, LW * FH);
    drain();
    check("bypass_random_frame_cnt", 32'(frame_cnt), 32'(N_OUT));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
